spi_slave_fl: RTL and testbench

SPI flash-responder block: the target end of the flash SPI link driven by the team's flash SPI master. It oversamples sclk/ss/mosi in the clk domain and decodes a command byte, an optional 24-bit address and optional 32-bit write data. It hands decoded frames to a local user port and, for read-type commands, shifts a 32-bit reply out on miso. It is used as a synthesizable flash stand-in for the master's loopback benches and as a target in FPGA tests.

---
 rtl/spi_fl_pkg.sv | 62 ++++++
 rtl/spi_slave_fl_if.sv | 31 +++
 rtl/spi_slave_sync.sv | 47 ++++
 rtl/spi_slave_fl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_slave_fl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_fl_pkg.sv
// Shared definitions for the flash SPI link: opcodes, frame types, field widths
// and the opcode-to-frame-type table.
package spi_fl_pkg;

  localparam int CMD_W  = 8;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int FT_W   = 3;

  localparam logic [CMD_W-1:0] OP_WREN = 8'h06;
  localparam logic [CMD_W-1:0] OP_RDSR = 8'h05;
  localparam logic [CMD_W-1:0] OP_RDID = 8'h9F;
  localparam logic [CMD_W-1:0] OP_READ = 8'h03;
  localparam logic [CMD_W-1:0] OP_WRSR = 8'h01;
  localparam logic [CMD_W-1:0] OP_PP   = 8'h02;
  localparam logic [CMD_W-1:0] OP_SE   = 8'h20;

  // Encodings match the master's commtype values.
  typedef enum logic [FT_W-1:0] {
    FT_CMD           = 3'd0,
    FT_CMD_ANS       = 3'd1,
    FT_CMD_ADDR_ANS  = 3'd2,
    FT_CMD_DATA      = 3'd3,
    FT_CMD_ADDR_DATA = 3'd4,
    FT_CMD_ADDR      = 3'd5
  } frame_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_RLOAD,
    ST_REPLY,
    ST_WAIT_SS
  } state_e;

  typedef struct packed {
    logic        known;
    frame_type_e ftype;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [CMD_W-1:0] op);
    cmd_dec_t d;
    d.known = 1'b1;
    case (op)
      OP_WREN:          d.ftype = FT_CMD;
      OP_RDSR, OP_RDID: d.ftype = FT_CMD_ANS;
      OP_READ:          d.ftype = FT_CMD_ADDR_ANS;
      OP_WRSR:          d.ftype = FT_CMD_DATA;
      OP_PP:            d.ftype = FT_CMD_ADDR_DATA;
      OP_SE:            d.ftype = FT_CMD_ADDR;
      default: begin
        d.known = 1'b0;
        d.ftype = FT_CMD;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spi_slave_fl_if.sv
// SPI pins plus the local user port of the flash responder.
interface spi_slave_fl_if;
  import spi_fl_pkg::*;

  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              frame_valid;
  logic [FT_W-1:0]   frame_type;
  logic [CMD_W-1:0]  cmd_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;

  modport slave (
    input  sclk, ss, mosi, rd_data,
    output miso, miso_oe, frame_valid, frame_type, cmd_out, addr_out, data_out,
           rd_req, frame_err
  );

  modport master (
    output sclk, ss, mosi, rd_data,
    input  miso, miso_oe, frame_valid, frame_type, cmd_out, addr_out, data_out,
           rd_req, frame_err
  );

endinterface

// File: rtl/spi_slave_sync.sv
// Brings sclk/ss/mosi into the clk domain and derives one-clk sclk edge strobes.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  output logic ss_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] ss_q, ss_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   sclk_prev_q, sclk_prev_d;

  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
    ss_d        = {ss_q[SYNC_STAGES-2:0], ss};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '0;
      ss_q        <= '0;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_prev_q;

endmodule

// File: rtl/spi_slave_fl.sv
// Flash SPI responder: decodes cmd/addr/data frames from the flash master and
// shifts a 32-bit reply on miso for read-type commands.
module spi_slave_fl
  import spi_fl_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spi_slave_fl_if.slave bus
);

  logic ss_s, mosi_s, sclk_rise, sclk_fall;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (bus.sclk),
    .ss        (bus.ss),
    .mosi      (bus.mosi),
    .ss_s      (ss_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [CMD_W-1:0]  cmd_sh_q, cmd_sh_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  frame_type_e       ftype_q, ftype_d;
  logic [1:0]        rload_cnt_q, rload_cnt_d;
  logic              fall_pend_q, fall_pend_d;
  logic              ss_prev_q, ss_prev_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rd_req_q, rd_req_d;
  frame_type_e       frame_type_q, frame_type_d;
  logic [CMD_W-1:0]  cmd_out_q, cmd_out_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  cmd_dec_t dec;
  logic     publish;
  logic     last_bit;

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    cmd_sh_d      = cmd_sh_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    tx_d          = tx_q;
    ftype_d       = ftype_q;
    rload_cnt_d   = rload_cnt_q;
    fall_pend_d   = fall_pend_q;
    ss_prev_d     = ss_s;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    rd_req_d      = 1'b0;
    frame_type_d  = frame_type_q;
    cmd_out_d     = cmd_out_q;
    addr_out_d    = addr_out_q;
    data_out_d    = data_out_q;
    publish       = 1'b0;
    last_bit      = (bitcnt_q == '0);
    dec           = decode_cmd({cmd_sh_q[CMD_W-2:0], mosi_s});

    if (ss_s && (state_q != ST_IDLE) && (state_q != ST_WAIT_SS)) begin
      frame_err_d = 1'b1;
      miso_d      = MISO_IDLE;
      miso_oe_d   = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_prev_q && !ss_s) begin
            state_d   = ST_CMD;
            bitcnt_d  = CNT_W'(CMD_W - 1);
            cmd_sh_d  = '0;
            addr_sh_d = '0;
            data_sh_d = '0;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            cmd_sh_d = {cmd_sh_q[CMD_W-2:0], mosi_s};
            bitcnt_d = bitcnt_q - 1'b1;
            if (last_bit) begin
              ftype_d     = dec.ftype;
              frame_err_d = ~dec.known;
              case (dec.ftype)
                FT_CMD: begin
                  publish = 1'b1;
                  state_d = ST_WAIT_SS;
                end
                FT_CMD_ANS:  state_d = ST_RLOAD;
                FT_CMD_DATA: begin
                  state_d  = ST_DATA;
                  bitcnt_d = CNT_W'(DATA_W - 1);
                end
                default: begin
                  state_d  = ST_ADDR;
                  bitcnt_d = CNT_W'(ADDR_W - 1);
                end
              endcase
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_s};
            bitcnt_d  = bitcnt_q - 1'b1;
            if (last_bit) begin
              case (ftype_q)
                FT_CMD_ADDR_ANS:  state_d = ST_RLOAD;
                FT_CMD_ADDR_DATA: begin
                  state_d  = ST_DATA;
                  bitcnt_d = CNT_W'(DATA_W - 1);
                end
                default: begin
                  publish = 1'b1;
                  state_d = ST_WAIT_SS;
                end
              endcase
            end
          end
        end

        ST_DATA: begin
          if (sclk_rise) begin
            data_sh_d = {data_sh_q[DATA_W-2:0], mosi_s};
            bitcnt_d  = bitcnt_q - 1'b1;
            if (last_bit) begin
              publish = 1'b1;
              state_d = ST_WAIT_SS;
            end
          end
        end

        // A fast sclk may fall before rd_data lands; remember it so bit 31
        // still goes out on that period.
        ST_RLOAD: begin
          rload_cnt_d = rload_cnt_q + 2'd1;
          if (sclk_fall) fall_pend_d = 1'b1;
          if (rload_cnt_q == 2'd2) begin
            tx_d     = bus.rd_data;
            state_d  = ST_REPLY;
            bitcnt_d = CNT_W'(DATA_W - 1);
            if (fall_pend_q || sclk_fall) begin
              miso_d    = bus.rd_data[DATA_W-1];
              miso_oe_d = 1'b1;
              bitcnt_d  = CNT_W'(DATA_W - 2);
            end
          end
        end

        // bitcnt wraps to all-ones once bit 0 is on the wire.
        ST_REPLY: begin
          if (sclk_fall) begin
            if (!bitcnt_q[CNT_W-1]) begin
              miso_d    = tx_q[bitcnt_q[4:0]];
              miso_oe_d = 1'b1;
              bitcnt_d  = bitcnt_q - 1'b1;
            end else begin
              miso_d    = MISO_IDLE;
              miso_oe_d = 1'b0;
            end
          end else if (sclk_rise && bitcnt_q[CNT_W-1]) begin
            publish   = 1'b1;
            state_d   = ST_WAIT_SS;
            miso_d    = MISO_IDLE;
            miso_oe_d = 1'b0;
          end
        end

        ST_WAIT_SS: begin
          if (ss_s) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    if ((state_d == ST_RLOAD) && (state_q != ST_RLOAD)) begin
      rd_req_d    = 1'b1;
      rload_cnt_d = 2'd0;
      fall_pend_d = 1'b0;
    end

    if (publish) begin
      frame_valid_d = 1'b1;
      frame_type_d  = ftype_d;
      cmd_out_d     = cmd_sh_d;
      addr_out_d    = addr_sh_d;
      data_out_d    = data_sh_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      cmd_sh_q      <= '0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      tx_q          <= '0;
      ftype_q       <= FT_CMD;
      rload_cnt_q   <= '0;
      fall_pend_q   <= 1'b0;
      ss_prev_q     <= 1'b0;
      miso_q        <= MISO_IDLE;
      miso_oe_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rd_req_q      <= 1'b0;
      frame_type_q  <= FT_CMD;
      cmd_out_q     <= '0;
      addr_out_q    <= '0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      cmd_sh_q      <= cmd_sh_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      tx_q          <= tx_d;
      ftype_q       <= ftype_d;
      rload_cnt_q   <= rload_cnt_d;
      fall_pend_q   <= fall_pend_d;
      ss_prev_q     <= ss_prev_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      rd_req_q      <= rd_req_d;
      frame_type_q  <= frame_type_d;
      cmd_out_q     <= cmd_out_d;
      addr_out_q    <= addr_out_d;
      data_out_q    <= data_out_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.frame_type  = frame_type_q;
  assign bus.cmd_out     = cmd_out_q;
  assign bus.addr_out    = addr_out_q;
  assign bus.data_out    = data_out_q;

endmodule

// File: tb/tb_spi_slave_fl.sv
// Drives whole SPI frames into spi_slave_fl and checks decoded outputs, pulses
// and the miso reply against a table-driven model of the flash command set.
module tb_spi_slave_fl;

  logic clk = 1'b0;
  logic rst;

  spi_slave_fl_if bus();

  spi_slave_fl #(
    .SYNC_STAGES(2),
    .MISO_IDLE  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int fv_cnt = 0;
  int fe_cnt = 0;
  int rq_cnt = 0;
  int oe_cnt = 0;
  logic [2:0]  cap_type;
  logic [7:0]  cap_cmd;
  logic [23:0] cap_addr;
  logic [31:0] cap_data;

  logic [31:0] reply_word = 32'h0;
  logic [2:0]  last_type  = 3'd0;
  logic [7:0]  last_cmd   = 8'h00;

  // Pulse/capture monitor, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        fv_cnt++;
        cap_type = bus.frame_type;
        cap_cmd  = bus.cmd_out;
        cap_addr = bus.addr_out;
        cap_data = bus.data_out;
      end
      if (bus.frame_err === 1'b1) fe_cnt++;
      if (bus.rd_req === 1'b1)    rq_cnt++;
      if (bus.miso_oe === 1'b1)   oe_cnt++;
    end
  end

  // User-side responder: reply word becomes valid two clocks after rd_req
  initial begin
    bus.rd_data = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      if (bus.rd_req === 1'b1) begin
        @(posedge clk);
        @(posedge clk);
        #1 bus.rd_data = reply_word;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI period: mosi set while sclk low, miso sampled just before the rise
  task automatic applyStimulus(input logic b, output logic m, output logic o);
    bus.mosi = b;
    waitClk(8);
    m = bus.miso;
    o = bus.miso_oe;
    bus.sclk = 1'b1;
    waitClk(8);
    bus.sclk = 1'b0;
  endtask

  function automatic void refDecode(input logic [7:0] c, output int ft, output bit known);
    known = 1'b1;
    case (c)
      8'h06:        ft = 0;
      8'h05, 8'h9F: ft = 1;
      8'h03:        ft = 2;
      8'h01:        ft = 3;
      8'h02:        ft = 4;
      8'h20:        ft = 5;
      default: begin
        ft    = 0;
        known = 1'b0;
      end
    endcase
  endfunction

  task automatic spiFrame(input logic [7:0] cmd, input logic [23:0] addr,
                          input logic [31:0] wdata, input logic [31:0] reply,
                          input int extra_bits);
    int ft;
    bit known, has_addr, has_data, has_reply, oe_all;
    bit hq[$];
    int fv0, fe0, rq0, oe0;
    logic m, o;
    logic [31:0] got;
    string p;
    refDecode(cmd, ft, known);
    has_addr  = (ft == 2) || (ft == 4) || (ft == 5);
    has_data  = (ft == 3) || (ft == 4);
    has_reply = (ft == 1) || (ft == 2);
    for (int i = 7; i >= 0; i--) hq.push_back(cmd[i]);
    if (has_addr) for (int i = 23; i >= 0; i--) hq.push_back(addr[i]);
    if (has_data) for (int i = 31; i >= 0; i--) hq.push_back(wdata[i]);
    p = $sformatf("cmd%02h", cmd);
    reply_word = reply;
    fv0 = fv_cnt; fe0 = fe_cnt; rq0 = rq_cnt; oe0 = oe_cnt;
    got = '0;
    oe_all = 1'b1;
    bus.ss = 1'b0;
    waitClk(4);
    foreach (hq[i]) applyStimulus(hq[i], m, o);
    if (has_reply) begin
      for (int j = 0; j < 32; j++) begin
        applyStimulus(1'($urandom), m, o);
        got = {got[30:0], m};
        oe_all = oe_all & (o === 1'b1);
      end
    end
    for (int j = 0; j < extra_bits; j++) applyStimulus(cmd[7 - (j % 8)], m, o);
    waitClk(4);
    bus.ss = 1'b1;
    waitClk(8);
    checkOutput({p, "_valid_pulses"}, fv_cnt - fv0, 1);
    checkOutput({p, "_err_pulses"}, fe_cnt - fe0, known ? 0 : 1);
    checkOutput({p, "_rdreq_pulses"}, rq_cnt - rq0, has_reply ? 1 : 0);
    checkOutput({p, "_type"}, 32'(cap_type), 32'(ft));
    checkOutput({p, "_cmd_out"}, 32'(cap_cmd), 32'(cmd));
    checkOutput({p, "_addr_out"}, 32'(cap_addr), has_addr ? 32'(addr) : 32'h0);
    checkOutput({p, "_data_out"}, cap_data, has_data ? wdata : 32'h0);
    if (has_reply) begin
      checkOutput({p, "_miso_word"}, got, reply);
      checkOutput({p, "_oe_during_reply"}, 32'(oe_all), 32'd1);
    end else begin
      checkOutput({p, "_oe_cycles"}, oe_cnt - oe0, 0);
    end
    checkOutput({p, "_miso_idle_after"}, 32'(bus.miso), 32'd1);
    checkOutput({p, "_oe_after"}, 32'(bus.miso_oe), 32'd0);
    last_type = 3'(ft);
    last_cmd  = cmd;
  endtask

  // Reply-type command with ss released after nbits reply bits
  task automatic abortReply(input logic [7:0] cmd, input logic [31:0] reply, input int nbits);
    int fv0, fe0, rq0;
    logic m, o;
    logic [31:0] got;
    reply_word = reply;
    fv0 = fv_cnt; fe0 = fe_cnt; rq0 = rq_cnt;
    got = '0;
    bus.ss = 1'b0;
    waitClk(4);
    for (int i = 7; i >= 0; i--) applyStimulus(cmd[i], m, o);
    for (int j = 0; j < nbits; j++) begin
      applyStimulus(1'($urandom), m, o);
      got = {got[30:0], m};
    end
    waitClk(4);
    bus.ss = 1'b1;
    waitClk(8);
    checkOutput("abort_err_pulses", fe_cnt - fe0, 1);
    checkOutput("abort_valid_pulses", fv_cnt - fv0, 0);
    checkOutput("abort_rdreq_pulses", rq_cnt - rq0, 1);
    checkOutput("abort_partial_reply", got, reply >> (32 - nbits));
    checkOutput("abort_miso_idle", 32'(bus.miso), 32'd1);
    checkOutput("abort_oe_low", 32'(bus.miso_oe), 32'd0);
    checkOutput("abort_type_held", 32'(bus.frame_type), 32'(last_type));
    checkOutput("abort_cmd_held", 32'(bus.cmd_out), 32'(last_cmd));
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
    checkOutput({p, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    checkOutput({p, "_rd_req"}, 32'(bus.rd_req), 32'd0);
    checkOutput({p, "_miso"}, 32'(bus.miso), 32'd1);
    checkOutput({p, "_miso_oe"}, 32'(bus.miso_oe), 32'd0);
    checkOutput({p, "_frame_type"}, 32'(bus.frame_type), 32'd0);
    checkOutput({p, "_cmd_out"}, 32'(bus.cmd_out), 32'd0);
    checkOutput({p, "_addr_out"}, 32'(bus.addr_out), 32'd0);
    checkOutput({p, "_data_out"}, bus.data_out, 32'd0);
  endtask

  initial begin
    logic [7:0]  se_cmd;
    logic [23:0] se_addr;
    logic [7:0]  ops [7];
    logic m, o;
    int fv0, fe0, rq0;
    logic [7:0]  rc;

    ops = '{8'h06, 8'h05, 8'h9F, 8'h03, 8'h01, 8'h02, 8'h20};
    bus.sclk = 1'b0;
    bus.ss   = 1'b1;
    bus.mosi = 1'b0;
    rst      = 1'b1;
    waitClk(5);
    checkResetValues("por");
    rst = 1'b0;
    waitClk(6);
    checkResetValues("post_por");

    $display("[TB] directed frames");
    spiFrame(8'h06, 24'h0, 32'h0, 32'h0, 8);
    spiFrame(8'h03, 24'h123456, 32'h0, 32'hDEADBEEF, 0);
    spiFrame(8'h02, 24'h000100, 32'hA5A50F0F, 32'h0, 0);
    spiFrame(8'h77, 24'h0, 32'h0, 32'h0, 0);
    abortReply(8'h9F, 32'h13579BDF, 10);
    spiFrame(8'h05, 24'h0, 32'h0, 32'hCAFEF00D, 0);

    $display("[TB] reset during address field");
    se_cmd  = 8'h20;
    se_addr = 24'h00ABCD;
    fv0 = fv_cnt; fe0 = fe_cnt; rq0 = rq_cnt;
    bus.ss = 1'b0;
    waitClk(4);
    for (int i = 7; i >= 0; i--) applyStimulus(se_cmd[i], m, o);
    for (int i = 23; i >= 14; i--) applyStimulus(se_addr[i], m, o);
    rst = 1'b1;
    waitClk(3);
    checkResetValues("midrst");
    rst = 1'b0;
    waitClk(4);
    bus.ss = 1'b1;
    waitClk(8);
    checkOutput("midrst_valid_pulses", fv_cnt - fv0, 0);
    checkOutput("midrst_err_pulses", fe_cnt - fe0, 0);
    checkOutput("midrst_rdreq_pulses", rq_cnt - rq0, 0);
    last_type = 3'd0;
    last_cmd  = 8'h00;
    spiFrame(se_cmd, se_addr, 32'h0, 32'h0, 0);

    $display("[TB] random frames");
    for (int k = 0; k < 6; k++) begin
      rc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 6)];
      spiFrame(rc, 24'($urandom), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
